// File: rtl/dram_resp_reorderer_pkg.sv
// Shared types for the DRAM response reorderer: the 513-bit MemResp word and the channel id.
// Imported by the reorderer top; holds no logic.
package dram_resp_reorderer_pkg;

    localparam int MEM_DATA_W = 512;

    typedef struct packed {
        logic                  valid;
        logic [MEM_DATA_W-1:0] data;
    } MemResp;

    typedef enum logic {
        DRAM_CHAN0 = 1'b0,
        DRAM_CHAN1 = 1'b1
    } DramChan;

endpackage

// File: rtl/fifo.sv
// Generic show-ahead FIFO of 2**LOG_DEPTH entries; pop_dat always shows the oldest entry.
// Latency: a push is visible on pop_dat the cycle after it is written.
// Backpressure: pushes while full and pops while empty are ignored.
module fifo #(
    parameter int WIDTH     = 8,
    parameter int LOG_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH:0]   cnt_q, cnt_d;
    logic                 do_push, do_pop;

    always_comb begin
        full     = (cnt_q == (LOG_DEPTH+1)'(DEPTH));
        empty    = (cnt_q == '0);
        do_push  = push_vld & ~full;
        do_pop   = pop_vld & ~empty;
        wr_ptr_d = wr_ptr_q + LOG_DEPTH'(do_push);
        rd_ptr_d = rd_ptr_q + LOG_DEPTH'(do_pop);
        cnt_d    = cnt_q + (LOG_DEPTH+1)'(do_push) - (LOG_DEPTH+1)'(do_pop);
        pop_dat  = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset; the count guards every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/dram_resp_reorderer.sv
// dram_resp_reorderer: restores issue order of read responses returning on DRAM channels 0/1.
// Latency: a response accepted in cycle N can appear on mem_resp_out in cycle N+1 at the earliest.
// Backpressure: each channel stalls only on its own full buffer; DRAM_RESP_REORDER_STATS_EN adds stall/pop counters.
module dram_resp_reorderer
    import dram_resp_reorderer_pkg::*;
#(
    parameter int LOG_DEPTH      = 9,
    parameter int RESP_LOG_DEPTH = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic        issue_chan,
    output logic        order_full_out,
    input  MemResp      mem_resp_c0_in,
    output logic        mem_resp_grant_c0_out,
    input  MemResp      mem_resp_c1_in,
    output logic        mem_resp_grant_c1_out,
    output MemResp      mem_resp_out,
    input  logic        mem_resp_grant_in,
`ifdef DRAM_RESP_REORDER_STATS_EN
    output logic [31:0] stall_cycles_out,
    output logic [31:0] resp_count_out,
`endif
    output logic        err_out
);
    localparam int CNT_W = LOG_DEPTH + 1;
    localparam int DAT_W = $bits(MemResp) - 1;

    logic                  oq_full, oq_empty, oq_push, oq_pop;
    logic [0:0]            oq_dat;
    logic [1:0]            buf_full, buf_empty, buf_push, buf_pop;
    logic [DAT_W-1:0]      buf_dat [2];
    DramChan               head_chan;
    logic                  head_sel, head_rdy;
    logic [1:0]            issue_inc, spur;
    logic [1:0][CNT_W-1:0] inflight_q, inflight_d;
    logic                  err_q, err_d;
`ifdef DRAM_RESP_REORDER_STATS_EN
    logic [31:0]           stall_q, stall_d;
    logic [31:0]           rcnt_q, rcnt_d;
`endif

    fifo #(.WIDTH(1), .LOG_DEPTH(LOG_DEPTH)) u_order_q (
        .clk      (clk),
        .reset_n  (rst_n),
        .push_vld (oq_push),
        .push_dat (issue_chan),
        .pop_vld  (oq_pop),
        .pop_dat  (oq_dat),
        .full     (oq_full),
        .empty    (oq_empty)
    );

    fifo #(.WIDTH(DAT_W), .LOG_DEPTH(RESP_LOG_DEPTH)) u_resp_buf0 (
        .clk      (clk),
        .reset_n  (rst_n),
        .push_vld (buf_push[0]),
        .push_dat (mem_resp_c0_in.data),
        .pop_vld  (buf_pop[0]),
        .pop_dat  (buf_dat[0]),
        .full     (buf_full[0]),
        .empty    (buf_empty[0])
    );

    fifo #(.WIDTH(DAT_W), .LOG_DEPTH(RESP_LOG_DEPTH)) u_resp_buf1 (
        .clk      (clk),
        .reset_n  (rst_n),
        .push_vld (buf_push[1]),
        .push_dat (mem_resp_c1_in.data),
        .pop_vld  (buf_pop[1]),
        .pop_dat  (buf_dat[1]),
        .full     (buf_full[1]),
        .empty    (buf_empty[1])
    );

    always_comb begin
        head_chan = DramChan'(oq_dat);
        head_sel  = (head_chan == DRAM_CHAN1);
        head_rdy  = ~oq_empty & ~buf_empty[head_sel];

        mem_resp_out.valid = head_rdy;
        mem_resp_out.data  = head_rdy ? buf_dat[head_sel] : '0;
        order_full_out     = oq_full;

        // Grants are held low while reset is asserted.
        buf_push[0] = rst_n & mem_resp_c0_in.valid & ~buf_full[0];
        buf_push[1] = rst_n & mem_resp_c1_in.valid & ~buf_full[1];
        mem_resp_grant_c0_out = buf_push[0];
        mem_resp_grant_c1_out = buf_push[1];

        oq_pop     = mem_resp_grant_in & head_rdy;
        buf_pop[0] = oq_pop & ~head_sel;
        buf_pop[1] = oq_pop & head_sel;

        // Fullness is judged before this cycle's pop, so a same-cycle dequeue never makes room.
        oq_push   = issue_valid & ~oq_full;
        issue_inc = {oq_push & issue_chan, oq_push & ~issue_chan};

        for (int c = 0; c < 2; c++) begin
            spur[c]       = buf_push[c] & (inflight_q[c] == '0);
            inflight_d[c] = inflight_q[c] + CNT_W'(issue_inc[c]) - CNT_W'(buf_push[c] & ~spur[c]);
        end

        err_d   = err_q | (issue_valid & oq_full) | (|spur);
        err_out = err_q;

`ifdef DRAM_RESP_REORDER_STATS_EN
        stall_d = stall_q;
        rcnt_d  = rcnt_q;
        if (~oq_empty & buf_empty[head_sel] & ~buf_empty[~head_sel] & (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
        if (oq_pop & (rcnt_q != 32'hFFFF_FFFF)) begin
            rcnt_d = rcnt_q + 32'd1;
        end
        stall_cycles_out = stall_q;
        resp_count_out   = rcnt_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
`ifdef DRAM_RESP_REORDER_STATS_EN
            stall_q    <= '0;
            rcnt_q     <= '0;
`endif
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
`ifdef DRAM_RESP_REORDER_STATS_EN
            stall_q    <= stall_d;
            rcnt_q     <= rcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_dram_resp_reorderer.sv
// Self-checking bench for dram_resp_reorderer: queue-level reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_dram_resp_reorderer;
    import dram_resp_reorderer_pkg::*;

    localparam int DEPTH = 512;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   issue_valid, issue_chan, mem_resp_grant_in;
    MemResp c0, c1, out;
    logic   full, g0, g1, err;
`ifdef DRAM_RESP_REORDER_STATS_EN
    logic [31:0] stall_cycles, resp_count;
`endif

    always #5 clk = ~clk;

    dram_resp_reorderer dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .issue_valid           (issue_valid),
        .issue_chan            (issue_chan),
        .order_full_out        (full),
        .mem_resp_c0_in        (c0),
        .mem_resp_grant_c0_out (g0),
        .mem_resp_c1_in        (c1),
        .mem_resp_grant_c1_out (g1),
        .mem_resp_out          (out),
        .mem_resp_grant_in     (mem_resp_grant_in),
`ifdef DRAM_RESP_REORDER_STATS_EN
        .stall_cycles_out      (stall_cycles),
        .resp_count_out        (resp_count),
`endif
        .err_out               (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [512:0] act, input logic [512:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: order queue of channel ids, one data queue per channel, in-flight counts.
    bit           m_oq[$];
    logic [511:0] m_b0[$];
    logic [511:0] m_b1[$];
    int           m_inf0, m_inf1;
    bit           m_err;

    always @(negedge clk) begin
        bit           e_full, e_g0, e_g1, hv, pre_full, ch;
        logic [511:0] hd;
        if (!rst_n) begin
            m_oq.delete(); m_b0.delete(); m_b1.delete();
            m_inf0 = 0; m_inf1 = 0; m_err = 0;
        end
        e_full = (m_oq.size() == DEPTH);
        e_g0   = rst_n && c0.valid && (m_b0.size() < DEPTH);
        e_g1   = rst_n && c1.valid && (m_b1.size() < DEPTH);
        hv = 0; hd = '0;
        if (m_oq.size() > 0) begin
            if (m_oq[0] == 1'b0 && m_b0.size() > 0) begin hv = 1; hd = m_b0[0]; end
            if (m_oq[0] == 1'b1 && m_b1.size() > 0) begin hv = 1; hd = m_b1[0]; end
        end
        check("m_full", 513'(full), 513'(e_full));
        check("m_g0",   513'(g0),   513'(e_g0));
        check("m_g1",   513'(g1),   513'(e_g1));
        check("m_out",  out,        {hv, hd});
        check("m_err",  513'(err),  513'(m_err));
        if (rst_n) begin
            pre_full = e_full;
            if (mem_resp_grant_in && hv) begin
                ch = m_oq.pop_front();
                if (ch == 1'b0) void'(m_b0.pop_front());
                else            void'(m_b1.pop_front());
            end
            if (e_g0) begin
                m_b0.push_back(c0.data);
                if (m_inf0 == 0) m_err = 1; else m_inf0--;
            end
            if (e_g1) begin
                m_b1.push_back(c1.data);
                if (m_inf1 == 0) m_err = 1; else m_inf1--;
            end
            if (issue_valid) begin
                if (pre_full) m_err = 1;
                else begin
                    m_oq.push_back(issue_chan);
                    if (issue_chan) m_inf1++; else m_inf0++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_chan  = 1'b0;
        c0          = '0;
        c1          = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    logic [511:0] d0, d1, d2, d5, dc0, dt;

    initial begin
        d0  = {16{32'hD000_0000}};
        d1  = {16{32'hD111_1111}};
        d2  = {16{32'hD222_2222}};
        d5  = {16{32'h5555_AAAA}};
        dc0 = {16{32'hC0C0_C0C0}};
        mem_resp_grant_in = 1'b1;
        idle();
        rst_n = 1'b0;
        tick();
        #1;
        check("rst_out", out, '0);
        check("rst_err", 513'(err), 513'(0));
        check("rst_full", 513'(full), 513'(0));
        rst_n = 1'b1;
        tick();

        // Scenario 1: issue c0,c1,c0; responses D1(c1), D0(c0), D2(c0).
        issue_valid = 1; issue_chan = 0; tick();
        issue_chan = 1; tick();
        issue_chan = 0; tick();
        issue_valid = 0;
        c1 = {1'b1, d1}; tick();
        c1 = '0; c0 = {1'b1, d0}; #1;
        check("s1_wait", 513'(out.valid), 513'(0));
        tick();
        c0 = {1'b1, d2}; #1;
        check("s1_d0", out, {1'b1, d0});
        tick();
        c0 = '0; #1;
        check("s1_d1", out, {1'b1, d1});
        tick();
        check("s1_d2", out, {1'b1, d2});
        tick();
        check("s1_empty", 513'(out.valid), 513'(0));
        check("s1_err", 513'(err), 513'(0));

        // Scenario 3: spurious c1 response with nothing in flight.
        c1 = {1'b1, d5}; #1;
        check("s3_grant", 513'(g1), 513'(1));
        tick();
        c1 = '0; #1;
        check("s3_err", 513'(err), 513'(1));
        repeat (5) tick();
        check("s3_sticky", 513'(err), 513'(1));
        do_reset();
        check("s3_clr", 513'(err), 513'(0));

        // Scenario 2: 512 issues fill the order queue, the 513th overflows.
        for (int i = 0; i < DEPTH; i++) begin
            issue_valid = 1; issue_chan = i[0]; tick();
        end
        #1;
        check("s2_full", 513'(full), 513'(1));
        check("s2_noerr", 513'(err), 513'(0));
        tick();
        issue_valid = 0; #1;
        check("s2_err", 513'(err), 513'(1));
        check("s2_still_full", 513'(full), 513'(1));
        do_reset();

        // Scenario 4: head on silent c0 while c1 fills its buffer.
        issue_valid = 1; issue_chan = 0; tick();
        issue_chan = 1;
        for (int i = 0; i < DEPTH - 1; i++) tick();
        issue_valid = 0;
        for (int i = 0; i < DEPTH; i++) begin
            dt = 512'(i) | {32'hC1C1_0000, 480'h0};
            c1 = {1'b1, dt}; tick();
        end
        #1;
        check("s4_bp", 513'(g1), 513'(0));
        check("s4_hold", 513'(out.valid), 513'(0));
        repeat (3) tick();
        c1 = '0;
        c0 = {1'b1, dc0}; tick();
        c0 = '0; #1;
        check("s4_c0_first", out, {1'b1, dc0});
        tick();
        dt = {32'hC1C1_0000, 480'h0};
        check("s4_c1_first", out, {1'b1, dt});
        repeat (DEPTH + 4) tick();
        check("s4_drained", 513'(out.valid), 513'(0));
        do_reset();

        // Scenario 5: user withholds grant for 20 cycles.
        issue_valid = 1; issue_chan = 0; tick();
        issue_valid = 0;
        mem_resp_grant_in = 0;
        c0 = {1'b1, d5}; tick();
        c0 = '0;
        for (int i = 0; i < 20; i++) begin
            #1;
            check("s5_stable", out, {1'b1, d5});
            tick();
        end
        mem_resp_grant_in = 1; tick();
        check("s5_popped", 513'(out.valid), 513'(0));

        // Scenario 6: reset with 5 outstanding reads, then a late response.
        for (int i = 0; i < 5; i++) begin
            issue_valid = 1; issue_chan = i[0]; tick();
        end
        issue_valid = 0;
        c0 = {1'b1, d0}; tick();
        c0 = {1'b1, d1};
        rst_n = 1'b0; #1;
        check("s6_out", out, '0);
        check("s6_g0", 513'(g0), 513'(0));
        check("s6_err", 513'(err), 513'(0));
        tick();
        rst_n = 1'b1;
        c0 = '0; #1;
        check("s6_full", 513'(full), 513'(0));
        c1 = {1'b1, d2}; tick();
        c1 = '0; #1;
        check("s6_spurious", 513'(err), 513'(1));
        tick();
        check("s6_no_out", 513'(out.valid), 513'(0));
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
